alu_result_accumulator: RTL and testbench
=========================================

ALU_RESULT_ACCUMULATOR -- requirements
Module: alu_result_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of each incoming ALU result.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator and output sum width.
REQ-003 SHALL have parameter CNT_W, default 4, batch length field width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  begin a new batch; sampled only in IDLE.
REQ-008 len  input  CNT_W  beats per batch, latched on start; value 0 means 2^CNT_W beats.
REQ-009 in_valid  input  1  upstream ALU result valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 in_data  input  DATA_W  ALU result, treated as unsigned.
REQ-012 in_op  input  1  1 = add in_data to accumulator, 0 = subtract in_data from accumulator.
REQ-013 out_valid  output  1  batch result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_sum  output  ACC_W  accumulated batch result, modulo 2^ACC_W.
REQ-016 out_ovf  output  1  sticky carry/borrow flag for the batch.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ACC, HOLD.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 -> latch len, clear accumulator, ovf and beat counter, next state ACC.
REQ-020 ACC: in_ready=1; a beat transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-021 Per transferred beat: acc <= acc + zero-extended in_data (in_op=1) or acc - zero-extended in_data (in_op=0), wrapping modulo 2^ACC_W.
REQ-022 out_ovf SHALL set on unsigned carry-out (add) or borrow (subtract), stay set until next start, never clear mid-batch.
REQ-023 Beat counter SHALL increment per transferred beat; on the beat that makes count equal the latched length, next state HOLD.
REQ-024 ACC with in_valid=0 SHALL hold accumulator, counter and state unchanged (unbounded stall allowed).
REQ-025 HOLD: in_ready=0, out_valid=1; out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-026 HOLD with out_ready=1 -> IDLE next cycle; out_valid drops same edge.
REQ-027 Latency: out_valid SHALL assert the cycle after the final beat transfers.
REQ-028 start SHALL be ignored in ACC and HOLD; start coincident with out_ready in HOLD is ignored and must be reasserted in IDLE.
REQ-029 Changes to len after start SHALL not affect the running batch.
REQ-030 out_sum SHALL hold its last value in IDLE until the next start clears it.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, acc=0, counter=0, out_sum=0, out_ovf=0, in_ready=0, out_valid=0, busy=0.
REQ-032 Reset mid-batch or in HOLD SHALL discard the batch with no out_valid pulse; reset overrides all other inputs.

Structure
REQ-033 Shared package alu_pkg SHALL hold DATA_W, ACC_W, CNT_W defaults and the state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2).
REQ-034 Beat counting SHALL be a sub-module alu_batch_counter (load, increment, terminal-count output); all else in the top module.

Verification
REQ-035 start, len=3; beats add 6, add 2, add 12 -> out_valid one cycle after third beat, out_sum=20, out_ovf=0.
REQ-036 start, len=2; beats sub 2, add 2 -> out_sum=0, out_ovf=1 (borrow on first beat stays sticky).
REQ-037 start, len=0; 16 beats add 15 with in_valid toggling every other cycle -> in_ready high throughout ACC, out_sum=240, out_ovf=0, exactly 16 transfers counted.
REQ-038 In HOLD hold out_ready=0 for 5 cycles then 1 while pulsing start -> out_sum stable 5 cycles, IDLE after handshake, no new batch started.
REQ-039 start, len=4; after 2 beats drive rst_n=0 one cycle -> busy=0, out_valid never asserts, out_sum=0; new batch len=1 add 7 -> out_sum=7.
REQ-040 Change len from 3 to 1 one cycle after start -> batch still takes 3 beats.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared defaults and FSM state encoding for the ALU result accumulator.
package alu_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ACC_W  = 8;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_batch_counter.sv
// Beat counter for one batch: load latches the length, inc counts beats,
// last_c flags that the next counted beat completes the batch.
module alu_batch_counter
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             inc,
  output logic             last_c
);

  // One extra bit so a zero length can stand for 2^CNT_W beats.
  localparam int unsigned LIM_W = CNT_W + 1;

  logic [LIM_W-1:0] count_q;
  logic [LIM_W-1:0] limit_q;
  logic [LIM_W-1:0] limit_c;

  // Map the raw length field onto the actual beat count.
  always_comb begin
    limit_c = LIM_W'(len);
    if (len == '0) begin
      limit_c = LIM_W'(1) << CNT_W;
    end
  end

  // Count and limit registers; load restarts the batch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else if (load) begin
      count_q <= '0;
      limit_q <= limit_c;
    end else if (inc) begin
      count_q <= count_q + LIM_W'(1);
    end
  end

  assign last_c = ((count_q + LIM_W'(1)) == limit_q);

endmodule

// File: rtl/alu_result_accumulator.sv
// Accumulates a batch of ALU results (add/subtract) into a wrapping sum with
// a sticky carry/borrow flag and hands the result downstream with valid/ready.
module alu_result_accumulator
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  // Extra top bit carries the unsigned carry-out or borrow of each step.
  localparam int unsigned SUM_W = ACC_W + 1;

  state_e           state_q;
  state_e           state_nxt;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_q;
  logic             ovf_nxt;
  logic [SUM_W-1:0] step_c;
  logic             cnt_load;
  logic             cnt_inc;
  logic             last_c;

  alu_batch_counter #(
    .CNT_W (CNT_W)
  ) u_batch_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .len    (len),
    .inc    (cnt_inc),
    .last_c (last_c)
  );

  // Next-state, accumulator update and counter control.
  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    ovf_nxt   = ovf_q;
    step_c    = '0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ACC;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_load  = 1'b1;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          if (in_op) begin
            step_c = {1'b0, acc_q} + SUM_W'(in_data);
          end else begin
            step_c = {1'b0, acc_q} - SUM_W'(in_data);
          end
          acc_nxt = step_c[ACC_W-1:0];
          ovf_nxt = ovf_q | step_c[ACC_W];
          cnt_inc = 1'b1;
          if (last_c) begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      acc_q     <= acc_nxt;
      ovf_q     <= ovf_nxt;
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_HOLD);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  assign out_sum = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized batches against an integer-arithmetic reference model.
module tb_alu_result_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len_i;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  alu_result_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int          len;
    int          n;
    logic [15:0] op;
    logic [63:0] dat;
    int          exp_sum;
    bit          exp_ovf;
    int          new_len;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one batch from IDLE through the output handshake and checks it.
  task automatic run_batch(input string nm, input int len, input int n,
                           input logic [15:0] op, input logic [63:0] dat,
                           input int exp_sum, input bit exp_ovf, input bit gaps,
                           input int hold_cyc, input int new_len);
    start = 1'b1;
    len_i = 4'(len);
    tick();
    start = 1'b0;
    if (new_len >= 0) len_i = 4'(new_len);
    else len_i = 4'($urandom);
    chk({nm, "/busy_start"}, 32'(busy), 1);
    chk({nm, "/in_ready_start"}, 32'(in_ready), 1);
    chk({nm, "/sum_cleared"}, 32'(out_sum), 0);
    chk({nm, "/ovf_cleared"}, 32'(out_ovf), 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 4'($urandom);
          tick();
          chk({nm, "/in_ready_stall"}, 32'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      in_op    = op[i];
      in_data  = dat[4*i +: 4];
      tick();
      in_valid = 1'b0;
      chk({nm, "/out_valid_beat"}, 32'(out_valid), 32'(i == n - 1));
    end
    chk({nm, "/sum"}, 32'(out_sum), 32'(exp_sum));
    chk({nm, "/ovf"}, 32'(out_ovf), 32'(exp_ovf));
    chk({nm, "/in_ready_hold"}, 32'(in_ready), 0);
    for (int h = 0; h < hold_cyc; h++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      tick();
      chk({nm, "/hold_valid"}, 32'(out_valid), 1);
      chk({nm, "/hold_sum"}, 32'(out_sum), 32'(exp_sum));
      chk({nm, "/hold_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "/valid_drop"}, 32'(out_valid), 0);
    chk({nm, "/busy_idle"}, 32'(busy), 0);
    chk({nm, "/sum_idle"}, 32'(out_sum), 32'(exp_sum));
  endtask

  vec_t vecs[5];

  initial begin
    int xfers;
    rst_n = 1'b0; start = 1'b0; len_i = '0; in_valid = 1'b0;
    in_data = '0; in_op = 1'b0; out_ready = 1'b0;

    // Reset overrides a concurrent start.
    start = 1'b1;
    tick(); tick();
    chk("reset/busy", 32'(busy), 0);
    chk("reset/in_ready", 32'(in_ready), 0);
    chk("reset/out_valid", 32'(out_valid), 0);
    chk("reset/sum", 32'(out_sum), 0);
    chk("reset/ovf", 32'(out_ovf), 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle/busy", 32'(busy), 0);

    // Directed vectors: beat i uses op[i] and dat nibble i.
    vecs[0] = '{"add3",    3,  3, 16'b111,   64'hC26,  20,  1'b0, -1};
    vecs[1] = '{"subadd",  2,  2, 16'b10,    64'h22,   0,   1'b1, -1};
    vecs[2] = '{"full16",  0, 16, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 240, 1'b0, -1};
    vecs[3] = '{"wrap",    1,  1, 16'b0,     64'h1,    255, 1'b1, -1};
    vecs[4] = '{"lenchg",  3,  3, 16'b111,   64'h111,  3,   1'b0, 1};
    for (int v = 0; v < 5; v++) begin
      run_batch(vecs[v].name, vecs[v].len, vecs[v].n, vecs[v].op, vecs[v].dat,
                vecs[v].exp_sum, vecs[v].exp_ovf, 1'b0, 1, vecs[v].new_len);
    end

    // len=0 with in_valid toggling: 16 transfers over 31 cycles.
    start = 1'b1; len_i = 4'd0;
    tick();
    start = 1'b0;
    xfers = 0;
    for (int i = 0; i < 31; i++) begin
      chk("toggle/in_ready", 32'(in_ready), 1);
      chk("toggle/no_valid", 32'(out_valid), 0);
      in_valid = (i % 2 == 0);
      in_op    = 1'b1;
      in_data  = 4'd15;
      if (in_valid && in_ready) xfers++;
      tick();
    end
    in_valid = 1'b0;
    chk("toggle/out_valid", 32'(out_valid), 1);
    chk("toggle/xfers", 32'(xfers), 16);
    chk("toggle/sum", 32'(out_sum), 240);
    chk("toggle/ovf", 32'(out_ovf), 0);

    // Hold 5 cycles, then handshake with a coincident start that must be ignored.
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("hold5/valid", 32'(out_valid), 1);
      chk("hold5/sum", 32'(out_sum), 240);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len_i     = 4'd2;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("hold5/valid_drop", 32'(out_valid), 0);
    chk("hold5/busy_idle", 32'(busy), 0);
    tick();
    chk("hold5/no_new_batch", 32'(busy), 0);
    chk("hold5/sum_kept", 32'(out_sum), 240);

    // Reset after two beats discards the batch.
    start = 1'b1; len_i = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 1'b1; in_data = 4'd5;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset/busy", 32'(busy), 0);
    chk("midreset/out_valid", 32'(out_valid), 0);
    chk("midreset/sum", 32'(out_sum), 0);
    chk("midreset/in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midreset/stay_idle", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    run_batch("after_reset", 1, 1, 16'b1, 64'h7, 7, 1'b0, 1'b0, 0, -1);

    // Randomized batches against an integer reference model.
    for (int t = 0; t < 30; t++) begin
      int n, a;
      bit o;
      logic [15:0] op;
      logic [63:0] dat;
      n = int'($urandom_range(1, 16));
      op = 16'($urandom);
      dat = {$urandom, $urandom};
      a = 0;
      o = 1'b0;
      for (int i = 0; i < n; i++) begin
        int d;
        d = int'(dat[4*i +: 4]);
        if (op[i]) a = a + d;
        else a = a - d;
        if (a > 255) begin o = 1'b1; a = a - 256; end
        if (a < 0) begin o = 1'b1; a = a + 256; end
      end
      run_batch($sformatf("rand%0d", t), n % 16, n, op, dat, a, o, 1'b1,
                int'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
